reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
- Control FSM for the reaction-timer game.
- Sequences the 3-digit BCD millisecond counter: clears it, waits a pseudo-random delay, lights the stimulus LED, then enables counting once per millisecond until the player presses stop.
- Flags early (cheat) presses and counter saturation at 999.
- Sits between the debounced push-buttons and the BCD counter's clk/reset/enable/ceo pins.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock); must be >= 2.
- DELAY_MIN_MS, 1000, minimum stimulus delay in ms; actual delay = DELAY_MIN_MS + lfsr[9:0] (0..1023).
- DLY_W, 12, width of the delay down-counter; must hold DELAY_MIN_MS + 1023.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  debounced start button, level, synchronous to clk.
- stop  in  1  debounced stop/react button, level, synchronous to clk.
- cnt_ceo  in  1  counter terminal flag (high when counter reads 999).
- cnt_clr  out  1  synchronous clear to the BCD counter's reset pin, active-high.
- cnt_en  out  1  count enable to the BCD counter.
- led  out  1  stimulus LED.
- tick  out  1  1 ms strobe, one clk wide.
- state  out  3  current FSM state code.
- done  out  1  valid result held on counter.
- early  out  1  stop pressed before the LED lit.
- timeout  out  1  counter saturated at 999 without a stop press.

Behaviour:
- **Reset** (reset=0, async):
  - state=IDLE; lfsr=16'hACE1; prescaler=0; delay counter=0.
  - start_q and stop_q are set to 1, so a button held through reset does not produce an edge.
  - Outputs during reset: cnt_clr=1, cnt_en=0, led=0, tick=0, done=early=timeout=0.
- **Edge detect:**
  - start_rise = start & ~start_q; stop_rise = stop & ~stop_q.
  - start_q/stop_q are registered every clk.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11; shifts every clk, free-running.
- **Prescaler:**
  - Counts 0..TICK_DIV-1; tick=1 in the cycle where it equals TICK_DIV-1, then it wraps to 0.
  - Forced to 0 on every transition into WAIT or RUN, so the first tick occurs TICK_DIV cycles after entry.
- **States** (code):
  - IDLE(0): cnt_clr=1. start_rise -> WAIT; delay counter loaded with DELAY_MIN_MS + lfsr[9:0].
  - WAIT(1): cnt_clr=1, led=0.
    - Delay counter decrements on each tick.
    - stop_rise -> EARLY (has priority).
    - Otherwise, tick while delay==1 -> RUN.
  - RUN(2): led=1, cnt_clr=0, cnt_en=tick & ~cnt_ceo.
    - stop_rise -> DONE, and cnt_en is forced to 0 in that same cycle.
    - Otherwise cnt_ceo=1 -> TIMEOUT.
    - If stop_rise and cnt_ceo are high together, DONE wins (999 ms is a valid result).
  - DONE(3) / EARLY(4) / TIMEOUT(5):
    - cnt_en=0, cnt_clr=0 (counter value held for display); led=0.
    - done/early/timeout respectively =1.
    - start_rise -> WAIT with a fresh delay load; cnt_clr reasserts in WAIT.
- **Ignored inputs:** start_rise in WAIT or RUN; stop_rise in IDLE, DONE, EARLY, TIMEOUT.
- **Illegal codes** 6 and 7 -> IDLE on the next clk.
- **Output timing:** all outputs are decoded from registered state/prescaler, no input-to-output combinational path, except that cnt_en is gated combinationally by stop_rise and cnt_ceo as stated above.
- **Mid-operation reset** returns to IDLE immediately; the counter is cleared via cnt_clr.
- **Counting:** the counter advances exactly once per tick while in RUN, so the displayed value equals elapsed ms since LED on, truncated.

Test Plan:
Bench parameters: TICK_DIV=4, DELAY_MIN_MS=2, BCD counter instantiated on cnt_clr/cnt_en/cnt_ceo.
1. Reset released with stop held high -> state=0, cnt_clr=1, no edge detected, state stays 0.
2. start pulse, stop pulse 10 ticks after led rises -> state goes 1 -> 2 -> 3; done=1; counter reads 010, unchanged for 100 further cycles.
3. start pulse, then stop pulse while in WAIT -> state=4, early=1, led never asserted, counter reads 000.
4. start pulse, no stop -> counter reaches 999, state=5, timeout=1, counter stays 999, cnt_en=0.
5. stop_rise in the same cycle cnt_ceo first goes high -> state=3 (not 5), counter 999.
6. reset asserted mid-RUN at count 005 -> async return to state 0, led=0; on the next clk edge the counter reads 000. Later start pulse: delay measured in ticks is within 2..1025.

Source files
------------

// File: rtl/reaction_timer_ctrl_if.sv
// ============================================================================
// reaction_timer_ctrl_if : button, BCD-counter and status signals of the
//                          reaction-timer controller
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface reaction_timer_ctrl_if;
  logic       start;
  logic       stop;
  logic       cnt_ceo;
  logic       cnt_clr;
  logic       cnt_en;
  logic       led;
  logic       tick;
  logic [2:0] state;
  logic       done;
  logic       early;
  logic       timeout;

  modport master (
    output start, stop, cnt_ceo,
    input  cnt_clr, cnt_en, led, tick, state, done, early, timeout
  );

  modport slave (
    input  start, stop, cnt_ceo,
    output cnt_clr, cnt_en, led, tick, state, done, early, timeout
  );
endinterface

`default_nettype wire

// File: rtl/reaction_timer_ctrl.sv
// ============================================================================
// reaction_timer_ctrl : FSM sequencing a 3-digit BCD ms counter for a
//                       reaction-timer game (random delay, LED, stop, flags)
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module reaction_timer_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int DELAY_MIN_MS = 1000,
  parameter int DLY_W        = 12
) (
  input wire                   clk_i,
  input wire                   rst_ni,
  reaction_timer_ctrl_if.slave ctl
);

  localparam int               c_pw        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_pw-1:0]  c_tick_last = c_pw'(TICK_DIV - 1);
  localparam logic [DLY_W-1:0] c_dly_min   = DLY_W'(DELAY_MIN_MS);
  localparam logic [DLY_W-1:0] c_dly_one   = DLY_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_EARLY   = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [c_pw-1:0]  presc_q, presc_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             start_q, stop_q;

  logic             w_tick;
  logic             w_start_rise;
  logic             w_stop_rise;
  logic             w_fb;
  logic [DLY_W-1:0] w_dly_load;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_led;
  logic             w_done;
  logic             w_early;
  logic             w_timeout;

  // Edge registers reset to 1 so a button held through reset is not an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      lfsr_q  <= 16'hACE1;
      presc_q <= '0;
      dly_q   <= '0;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      presc_q <= presc_d;
      dly_q   <= dly_d;
      start_q <= ctl.start;
      stop_q  <= ctl.stop;
    end
  end

  // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
  assign w_fb       = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d     = {w_fb, lfsr_q[15:1]};
  assign w_dly_load = c_dly_min + DLY_W'(lfsr_q[9:0]);

  assign w_tick       = (presc_q == c_tick_last);
  assign w_start_rise = ctl.start & ~start_q;
  assign w_stop_rise  = ctl.stop & ~stop_q;

  always_comb begin
    state_d   = state_q;
    presc_d   = w_tick ? '0 : presc_q + 1'b1;
    dly_d     = dly_q;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    w_led     = 1'b0;
    w_done    = 1'b0;
    w_early   = 1'b0;
    w_timeout = 1'b0;

    case (state_q)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_start_rise) begin
          state_d = S_WAIT;
          dly_d   = w_dly_load;
          presc_d = '0;
        end
      end

      S_WAIT: begin
        w_cnt_clr = 1'b1;
        if (w_tick) begin
          dly_d = dly_q - 1'b1;
        end
        if (w_stop_rise) begin
          state_d = S_EARLY;
        end else if (w_tick && (dly_q == c_dly_one)) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end

      S_RUN: begin
        w_led    = 1'b1;
        // A stop in the same cycle as a tick must not bump the displayed result.
        w_cnt_en = w_tick & ~ctl.cnt_ceo & ~w_stop_rise;
        if (w_stop_rise) begin
          state_d = S_DONE;
        end else if (ctl.cnt_ceo) begin
          state_d = S_TIMEOUT;
        end
      end

      S_DONE, S_EARLY, S_TIMEOUT: begin
        w_done    = (state_q == S_DONE);
        w_early   = (state_q == S_EARLY);
        w_timeout = (state_q == S_TIMEOUT);
        if (w_start_rise) begin
          state_d = S_WAIT;
          dly_d   = w_dly_load;
          presc_d = '0;
        end
      end

      default: begin
        w_cnt_clr = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign ctl.cnt_clr = w_cnt_clr;
  assign ctl.cnt_en  = w_cnt_en;
  assign ctl.led     = w_led;
  assign ctl.tick    = w_tick;
  assign ctl.state   = state_q;
  assign ctl.done    = w_done;
  assign ctl.early   = w_early;
  assign ctl.timeout = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_reaction_timer_ctrl.sv
// ============================================================================
// tb_reaction_timer_ctrl : directed bench for reaction_timer_ctrl driving a
//                          behavioural 3-digit BCD counter
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reaction_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reaction_timer_ctrl_if ifc ();

  reaction_timer_ctrl #(
    .TICK_DIV     (4),
    .DELAY_MIN_MS (2),
    .DLY_W        (12)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ctl    (ifc)
  );

  // Behavioural BCD counter with synchronous clear.
  logic [3:0]  r_d0, r_d1, r_d2;
  logic [11:0] w_cnt;

  always_ff @(posedge clk) begin
    if (ifc.cnt_clr) begin
      r_d0 <= 4'd0;
      r_d1 <= 4'd0;
      r_d2 <= 4'd0;
    end else if (ifc.cnt_en) begin
      if (r_d0 == 4'd9) begin
        r_d0 <= 4'd0;
        if (r_d1 == 4'd9) begin
          r_d1 <= 4'd0;
          r_d2 <= (r_d2 == 4'd9) ? 4'd0 : r_d2 + 4'd1;
        end else begin
          r_d1 <= r_d1 + 4'd1;
        end
      end else begin
        r_d0 <= r_d0 + 4'd1;
      end
    end
  end

  assign w_cnt       = {r_d2, r_d1, r_d0};
  assign ifc.cnt_ceo = (w_cnt == 12'h999);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] code, input int budget, output int cycles);
    cycles = 0;
    while ((ifc.state !== code) && (cycles < budget)) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int ticks;

    // 1: reset with both buttons held
    rst_n     = 1'b0;
    ifc.start = 1'b1;
    ifc.stop  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state",   ifc.state, 3'd0);
    chk("rst_cnt_clr", ifc.cnt_clr, 1'b1);
    chk("rst_cnt_en",  ifc.cnt_en, 1'b0);
    chk("rst_led",     ifc.led, 1'b0);
    chk("rst_tick",    ifc.tick, 1'b0);
    chk("rst_flags",   {ifc.done, ifc.early, ifc.timeout}, 3'b000);
    chk("rst_cnt",     w_cnt, 12'h000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t1_hold_idle", ifc.state, 3'd0);
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    @(negedge clk);

    // 2: normal run, stop after 10 ticks
    pulse_start();
    chk("t2_wait", ifc.state, 3'd1);
    chk("t2_led_off", ifc.led, 1'b0);
    wait_state(3'd2, 4200, cyc);
    chk("t2_run", ifc.state, 3'd2);
    chk("t2_led_on", ifc.led, 1'b1);
    repeat (40) @(negedge clk);
    chk("t2_cnt10_pre", w_cnt, 12'h010);
    ifc.stop = 1'b1;
    @(negedge clk);
    chk("t2_done_state", ifc.state, 3'd3);
    chk("t2_done_flag", ifc.done, 1'b1);
    chk("t2_led_off2", ifc.led, 1'b0);
    chk("t2_cnt10", w_cnt, 12'h010);
    ifc.stop = 1'b0;
    repeat (100) @(negedge clk);
    chk("t2_cnt_held", w_cnt, 12'h010);
    chk("t2_state_held", ifc.state, 3'd3);

    // 3: early press during WAIT
    pulse_start();
    chk("t3_wait", ifc.state, 3'd1);
    repeat (2) @(negedge clk);
    ifc.stop = 1'b1;
    @(negedge clk);
    chk("t3_early_state", ifc.state, 3'd4);
    chk("t3_early_flag", ifc.early, 1'b1);
    chk("t3_led", ifc.led, 1'b0);
    chk("t3_cnt", w_cnt, 12'h000);
    ifc.stop = 1'b0;
    repeat (10) @(negedge clk);
    chk("t3_state_held", ifc.state, 3'd4);

    // 4: no stop, counter saturates
    pulse_start();
    chk("t4_wait", ifc.state, 3'd1);
    wait_state(3'd2, 4200, cyc);
    chk("t4_run", ifc.state, 3'd2);
    wait_state(3'd5, 4200, cyc);
    chk("t4_timeout_state", ifc.state, 3'd5);
    chk("t4_timeout_flag", ifc.timeout, 1'b1);
    chk("t4_cnt999", w_cnt, 12'h999);
    chk("t4_cnt_en", ifc.cnt_en, 1'b0);
    repeat (50) @(negedge clk);
    chk("t4_cnt_held", w_cnt, 12'h999);
    chk("t4_state_held", ifc.state, 3'd5);

    // 5: stop coincides with first cycle of cnt_ceo
    pulse_start();
    wait_state(3'd2, 4200, cyc);
    chk("t5_run", ifc.state, 3'd2);
    cyc = 0;
    while ((ifc.cnt_ceo !== 1'b1) && (cyc < 4200)) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_ceo_seen", ifc.cnt_ceo, 1'b1);
    ifc.stop = 1'b1;
    @(negedge clk);
    chk("t5_done_state", ifc.state, 3'd3);
    chk("t5_done_flag", ifc.done, 1'b1);
    chk("t5_cnt999", w_cnt, 12'h999);
    ifc.stop = 1'b0;
    @(negedge clk);

    // 6: asynchronous reset mid-RUN, then delay range
    pulse_start();
    wait_state(3'd2, 4200, cyc);
    chk("t6_run", ifc.state, 3'd2);
    repeat (20) @(negedge clk);
    chk("t6_cnt5", w_cnt, 12'h005);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_state", ifc.state, 3'd0);
    chk("t6_async_led", ifc.led, 1'b0);
    chk("t6_async_clr", ifc.cnt_clr, 1'b1);
    @(negedge clk);
    chk("t6_cnt_cleared", w_cnt, 12'h000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    chk("t6_wait", ifc.state, 3'd1);
    wait_state(3'd2, 4200, cyc);
    chk("t6_run2", ifc.state, 3'd2);
    ticks = cyc / 4;
    chk("t6_dly_whole_ticks", cyc % 4, 0);
    chk("t6_dly_range", ((ticks >= 2) && (ticks <= 1025)) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
